// File: rtl/cha0s_fsm_ctrl.sv
// rtl/cha0s_fsm_ctrl.sv - multi-cycle fetch/decode/execute/memory/commit controller for the xcHa0s core
module cha0s_fsm_ctrl #(
    parameter int INSTR_W      = 16,
    parameter int NREGS        = 3,
    parameter int OPSEL_W      = 5,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               fetch_req,
    input  logic               alu_ready,
    input  logic               mem_ready,
    input  logic [3:0]         flags,
    output logic               alu_start,
    output logic [OPSEL_W-1:0] opsel,
    output logic [1:0]         sel_srcA,
    output logic [1:0]         sel_srcB,
    output logic [1:0]         data_addr_sel,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               mem_data_wr_sel,
    output logic               push,
    output logic               op_stack,
    output logic               wr_from_mem,
    output logic [NREGS-1:0]   wr_reg,
    output logic               save_flags,
    output logic               loadPC,
    output logic               branch,
    output logic               ret,
    output logic               illegal,
    output logic               fault,
    output logic               halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_COMMIT,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ALU   = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_STORE = 4'h3;
    localparam logic [3:0] OP_BR    = 4'h4;
    localparam logic [3:0] OP_CALL  = 4'h5;
    localparam logic [3:0] OP_RET   = 4'h6;
    localparam logic [3:0] OP_PUSH  = 4'h7;
    localparam logic [3:0] OP_POP   = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Counter is wide enough to hold WAIT_TIMEOUT and saturates instead of wrapping,
    // so "counter == 0" reliably marks the first wait cycle even with no timeout.
    localparam int              CNT_W     = $clog2(WAIT_TIMEOUT + 2);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1);
    localparam logic [2:0]       NREGS_L   = 3'(NREGS);

    state_t             state;
    state_t             state_nxt;
    logic [INSTR_W-1:0] ir;
    logic [CNT_W-1:0]   wait_cnt;
    logic               br_taken;
    logic               fault_q;

    logic [3:0] opcode;
    logic [1:0] dest;
    logic       dest_bad;
    logic       writes_dest;
    logic       known_op;
    logic       decode_illegal;
    logic       is_rd;
    logic       is_wr;
    logic       is_stack;
    logic       is_push;
    logic       is_load;
    logic       waiting;
    logic       ready_now;
    logic       timeout_hit;
    logic       taken_now;

    function automatic logic [NREGS-1:0] onehot(input logic [1:0] idx);
        logic [NREGS-1:0] oh;
        for (int r = 0; r < NREGS; r++) begin
            oh[r] = (idx == 2'(r));
        end
        return oh;
    endfunction

    assign opcode      = ir[INSTR_W-1 -: 4];
    assign dest        = ir[11:10];
    assign dest_bad    = ({1'b0, dest} >= NREGS_L);
    assign writes_dest = (opcode == OP_ALU) || (opcode == OP_LOAD) || (opcode == OP_POP);
    assign known_op    = (opcode <= OP_POP) || (opcode == OP_HALT);
    assign decode_illegal = !known_op || (writes_dest && dest_bad);

    assign is_rd    = (opcode == OP_LOAD) || (opcode == OP_RET) || (opcode == OP_POP);
    assign is_wr    = (opcode == OP_STORE) || (opcode == OP_PUSH) || (opcode == OP_CALL);
    assign is_stack = (opcode == OP_CALL) || (opcode == OP_RET) ||
                      (opcode == OP_PUSH) || (opcode == OP_POP);
    assign is_push  = (opcode == OP_PUSH) || (opcode == OP_CALL);
    assign is_load  = (opcode == OP_LOAD) || (opcode == OP_POP);

    assign waiting     = (state == S_EXEC) || (state == S_MEM);
    assign ready_now   = (state == S_EXEC) ? alu_ready : mem_ready;
    // A ready in the limit cycle takes priority over the timeout.
    assign timeout_hit = (WAIT_TIMEOUT != 0) && waiting && (wait_cnt == WAIT_LAST) && !ready_now;

    // Branch condition: an empty mask is unconditional, otherwise any masked flag (optionally inverted).
    assign taken_now = (ir[11:8] == 4'b0000) || ((|(flags & ir[11:8])) ^ ir[7]);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Instruction register, branch decision, wait counter and sticky fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir       <= '0;
            br_taken <= 1'b0;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            if (state == S_FETCH && instr_valid) begin
                ir <= instr;
            end
            if (state == S_DECODE) begin
                br_taken <= taken_now;
            end
            if (waiting && !ready_now) begin
                if (wait_cnt != '1) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
            if (timeout_hit) begin
                fault_q <= 1'b1;
            end
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (instr_valid) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (decode_illegal) begin
                    state_nxt = S_COMMIT;
                end else begin
                    case (opcode)
                        OP_ALU:   state_nxt = S_EXEC;
                        OP_LOAD,
                        OP_STORE,
                        OP_CALL,
                        OP_RET,
                        OP_PUSH,
                        OP_POP:   state_nxt = S_MEM;
                        OP_HALT:  state_nxt = S_HALT;
                        default:  state_nxt = S_COMMIT;
                    endcase
                end
            end
            S_EXEC: begin
                if (alu_ready)        state_nxt = S_COMMIT;
                else if (timeout_hit) state_nxt = S_HALT;
            end
            S_MEM: begin
                if (mem_ready)        state_nxt = S_COMMIT;
                else if (timeout_hit) state_nxt = S_HALT;
            end
            S_COMMIT: state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Output decode from state and IR.
    always_comb begin
        fetch_req       = 1'b0;
        alu_start       = 1'b0;
        opsel           = '0;
        sel_srcA        = 2'b00;
        sel_srcB        = 2'b00;
        data_addr_sel   = 2'b00;
        mem_rd          = 1'b0;
        mem_wr          = 1'b0;
        mem_data_wr_sel = 1'b0;
        push            = 1'b0;
        op_stack        = 1'b0;
        wr_from_mem     = 1'b0;
        wr_reg          = '0;
        save_flags      = 1'b0;
        loadPC          = 1'b0;
        branch          = 1'b0;
        ret             = 1'b0;
        illegal         = 1'b0;
        fault           = fault_q;
        halted          = 1'b0;
        case (state)
            S_FETCH: fetch_req = 1'b1;
            S_DECODE: illegal = decode_illegal;
            S_EXEC: begin
                opsel     = ir[OPSEL_W-1:0];
                sel_srcA  = ir[9:8];
                sel_srcB  = ir[7:6];
                alu_start = (wait_cnt == '0);
                if (alu_ready) begin
                    wr_reg     = onehot(dest);
                    save_flags = ir[5];
                end
            end
            S_MEM: begin
                data_addr_sel   = ir[9:8];
                mem_rd          = is_rd;
                mem_wr          = is_wr;
                mem_data_wr_sel = is_wr & ir[7];
                op_stack        = is_stack;
                push            = is_push;
                if (mem_ready && is_load) begin
                    wr_from_mem = 1'b1;
                    wr_reg      = onehot(dest);
                end
            end
            S_COMMIT: begin
                loadPC = 1'b1;
                branch = (opcode == OP_CALL) || ((opcode == OP_BR) && br_taken);
                ret    = (opcode == OP_RET);
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cha0s_fsm_ctrl.sv
// tb/tb_cha0s_fsm_ctrl.sv - table-driven self-checking bench for cha0s_fsm_ctrl
module tb_cha0s_fsm_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        fetch_req;
    logic        alu_ready;
    logic        mem_ready;
    logic [3:0]  flags;
    logic        alu_start;
    logic [4:0]  opsel;
    logic [1:0]  sel_srcA;
    logic [1:0]  sel_srcB;
    logic [1:0]  data_addr_sel;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_data_wr_sel;
    logic        push;
    logic        op_stack;
    logic        wr_from_mem;
    logic [2:0]  wr_reg;
    logic        save_flags;
    logic        loadPC;
    logic        branch;
    logic        ret;
    logic        illegal;
    logic        fault;
    logic        halted;

    int n_cmp = 0;
    int n_bad = 0;

    cha0s_fsm_ctrl #(
        .INSTR_W(16), .NREGS(3), .OPSEL_W(5), .WAIT_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .fetch_req(fetch_req), .alu_ready(alu_ready), .mem_ready(mem_ready),
        .flags(flags), .alu_start(alu_start), .opsel(opsel),
        .sel_srcA(sel_srcA), .sel_srcB(sel_srcB), .data_addr_sel(data_addr_sel),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_data_wr_sel(mem_data_wr_sel),
        .push(push), .op_stack(op_stack), .wr_from_mem(wr_from_mem),
        .wr_reg(wr_reg), .save_flags(save_flags), .loadPC(loadPC),
        .branch(branch), .ret(ret), .illegal(illegal), .fault(fault),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  flags;
        int          dly;
        int          cyc;
        int          starts;
        logic [8:0]  sel;
        logic [2:0]  wr;
        int          save;
        int          frm;
        logic        rd;
        logic        wrm;
        logic        psh;
        logic        stk;
        logic [2:0]  adr;
        logic        br;
        logic        rt;
        int          ill;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n = 0, starts = 0, wr_cnt = 0, save_cnt = 0, frm_cnt = 0;
        int lpc_cnt = 0, ill_cnt = 0, alu_k = 0, mem_k = 0;
        logic alu_act = 0, mem_act = 0, wr_stray = 0;
        logic saw_rd = 0, saw_wr = 0, saw_psh = 0, saw_stk = 0, br_o = 0, rt_o = 0;
        logic [8:0] sel_o = '0;
        logic [2:0] adr_o = '0, wr_o = '0;
        bit done = 0;
        instr = v.instr;
        flags = v.flags;
        instr_valid = 1'b1;
        @(posedge clk);
        // keep valid high with a HALT word to show it is ignored outside FETCH
        #1 instr = 16'hF000;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            alu_ready = 1'b0;
            mem_ready = 1'b0;
            if (fetch_req) begin
                instr_valid = 1'b0;
                done = 1;
            end else begin
                if (alu_start) begin
                    starts++;
                    sel_o = {sel_srcA, sel_srcB, opsel};
                    alu_act = 1;
                end
                if (alu_act) begin
                    if (alu_k == v.dly) begin
                        alu_ready = 1'b1;
                        alu_act = 0;
                    end
                    alu_k++;
                end
                if (mem_rd || mem_wr) begin
                    if (mem_k == 0) adr_o = {data_addr_sel, mem_data_wr_sel};
                    if (mem_k == v.dly) mem_ready = 1'b1;
                    mem_k++;
                end
                saw_rd  |= mem_rd;
                saw_wr  |= mem_wr;
                saw_psh |= push;
                saw_stk |= op_stack;
                if (illegal) ill_cnt++;
                if (loadPC) begin
                    lpc_cnt++;
                    br_o = branch;
                    rt_o = ret;
                end
                #1;
                if (wr_reg != 3'b000) begin
                    wr_cnt++;
                    wr_o = wr_reg;
                    if (!(alu_ready || mem_ready)) wr_stray = 1;
                end
                if (save_flags) save_cnt++;
                if (wr_from_mem) frm_cnt++;
            end
        end
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        instr_valid = 1'b0;
        check($sformatf("v%0d_return_to_fetch", idx), int'(done), 1);
        check($sformatf("v%0d_cycles", idx), n, v.cyc);
        check($sformatf("v%0d_alu_start", idx), starts, v.starts);
        check($sformatf("v%0d_alu_sel", idx), int'(sel_o), int'(v.sel));
        check($sformatf("v%0d_wr_reg", idx), int'(wr_o), int'(v.wr));
        check($sformatf("v%0d_wr_cnt", idx), wr_cnt, (v.wr != 3'b000) ? 1 : 0);
        check($sformatf("v%0d_wr_stray", idx), int'(wr_stray), 0);
        check($sformatf("v%0d_save_flags", idx), save_cnt, v.save);
        check($sformatf("v%0d_wr_from_mem", idx), frm_cnt, v.frm);
        check($sformatf("v%0d_mem_rd", idx), int'(saw_rd), int'(v.rd));
        check($sformatf("v%0d_mem_wr", idx), int'(saw_wr), int'(v.wrm));
        check($sformatf("v%0d_push", idx), int'(saw_psh), int'(v.psh));
        check($sformatf("v%0d_op_stack", idx), int'(saw_stk), int'(v.stk));
        check($sformatf("v%0d_addr_dsel", idx), int'(adr_o), int'(v.adr));
        check($sformatf("v%0d_loadPC", idx), lpc_cnt, 1);
        check($sformatf("v%0d_branch", idx), int'(br_o), int'(v.br));
        check($sformatf("v%0d_ret", idx), int'(rt_o), int'(v.rt));
        check($sformatf("v%0d_illegal", idx), ill_cnt, v.ill);
    endtask

    initial begin
        int n_rd;
        logic wr_seen;
        //           instr     flags dly cyc st  sel     wr     sv fm rd wm ps sk adr     br rt il
        vecs[0]  = '{16'h0000, 4'h0, 0, 3, 0, 9'h000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0};
        vecs[1]  = '{16'h1A63, 4'h0, 3, 7, 1, 9'h123, 3'b100, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0};
        vecs[2]  = '{16'h1185, 4'h0, 0, 4, 1, 9'h0C5, 3'b001, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0};
        vecs[3]  = '{16'h4400, 4'h4, 0, 3, 0, 9'h000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0};
        vecs[4]  = '{16'h4400, 4'h0, 0, 3, 0, 9'h000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0};
        vecs[5]  = '{16'h4480, 4'h4, 0, 3, 0, 9'h000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0};
        vecs[6]  = '{16'h4480, 4'h0, 0, 3, 0, 9'h000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0};
        vecs[7]  = '{16'h4080, 4'h0, 0, 3, 0, 9'h000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0};
        vecs[8]  = '{16'h4980, 4'h1, 0, 3, 0, 9'h000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0};
        vecs[9]  = '{16'h5000, 4'h0, 2, 6, 0, 9'h000, 3'b000, 0, 0, 0, 1, 1, 1, 3'b000, 1, 0, 0};
        vecs[10] = '{16'h6000, 4'h0, 2, 6, 0, 9'h000, 3'b000, 0, 0, 1, 0, 0, 1, 3'b000, 0, 1, 0};
        vecs[11] = '{16'h2600, 4'h0, 1, 5, 0, 9'h000, 3'b010, 0, 1, 1, 0, 0, 0, 3'b100, 0, 0, 0};
        vecs[12] = '{16'h3380, 4'h0, 0, 4, 0, 9'h000, 3'b000, 0, 0, 0, 1, 0, 0, 3'b111, 0, 0, 0};
        vecs[13] = '{16'h7000, 4'h0, 0, 4, 0, 9'h000, 3'b000, 0, 0, 0, 1, 1, 1, 3'b000, 0, 0, 0};
        vecs[14] = '{16'h8800, 4'h0, 0, 4, 0, 9'h000, 3'b100, 0, 1, 1, 0, 0, 1, 3'b000, 0, 0, 0};
        vecs[15] = '{16'hB000, 4'h0, 0, 3, 0, 9'h000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1};
        vecs[16] = '{16'h1C00, 4'h0, 0, 3, 0, 9'h000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1};
        vecs[17] = '{16'h8C00, 4'h0, 0, 3, 0, 9'h000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1};

        instr = 16'h0000;
        flags = 4'h0;
        do_reset();
        check("rst_fetch_req", int'(fetch_req), 1);
        check("rst_loadPC", int'(loadPC), 0);
        check("rst_wr_reg", int'(wr_reg), 0);
        check("rst_mem_wr", int'(mem_wr), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_halted", int'(halted), 0);

        for (int i = 0; i < 18; i++) begin
            run_vec(i, vecs[i]);
        end

        // reset in the middle of an ALU wait: nothing commits afterwards
        instr = 16'h1A63;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_alu_start", int'(alu_start), 1);
        rst = 1'b1;
        alu_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        alu_ready = 1'b0;
        @(negedge clk);
        check("midrst_wr_reg", int'(wr_reg), 0);
        check("midrst_loadPC", int'(loadPC), 0);
        check("midrst_fetch_req", int'(fetch_req), 1);

        // HALT opcode parks the core until reset
        instr = 16'hF000;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        check("halt_decode_halted", int'(halted), 0);
        @(negedge clk);
        check("halt_halted", int'(halted), 1);
        check("halt_fetch_req", int'(fetch_req), 0);
        check("halt_fault", int'(fault), 0);
        do_reset();

        // LOAD with mem_ready held low times out after 4 wait cycles
        instr = 16'h2400;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        n_rd = 0;
        wr_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_rd) n_rd++;
            if (wr_reg != 3'b000) wr_seen = 1'b1;
        end
        check("to_rd_cycles", n_rd, 4);
        check("to_fault_early", int'(fault), 0);
        @(negedge clk);
        check("to_fault", int'(fault), 1);
        check("to_halted", int'(halted), 1);
        check("to_no_wr", int'(wr_seen), 0);
        instr = 16'h0000;
        instr_valid = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("to_stays_halted", int'(halted), 1);
        check("to_no_fetch", int'(fetch_req), 0);
        check("to_fault_sticky", int'(fault), 1);
        do_reset();
        check("to_rst_fault", int'(fault), 0);
        check("to_rst_fetch", int'(fetch_req), 1);
        check("to_rst_halted", int'(halted), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
